// File: rtl/bp_sat_table.sv
// ---------------------------------------------------------------------------
// bp_sat_table
//
// Direct-mapped branch predictor table of 2^IDX_W saturating counters
// (CNT_W bits each), indexed by word-aligned PC bits pc[IDX_W+1:2].
// A lookup returns a registered prediction one cycle later. Resolved
// branch outcomes are applied through a separate update port as a
// saturating read-modify-write. Running, saturating counts of applied
// updates and mispredictions are kept for performance analysis.
//
// Optional feature (compile-time macro BP_GSHARE_EN):
//   When defined, an IDX_W-bit global history register is XORed into both
//   the lookup and the update index (gshare). When undefined, the table is
//   indexed purely by PC.
//
// Parameters:
//   CNT_W  - counter width in bits (1..4)
//   IDX_W  - index width, table depth = 2^IDX_W
//   PC_W   - PC width, must be >= IDX_W+2
//   STAT_W - width of the statistics counters
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high; clears table, outputs, stats
//   pred_valid     in   lookup request this cycle
//   pred_pc        in   PC being looked up
//   pred_out_valid out  one-cycle pulse after an accepted lookup
//   pred_taken     out  registered prediction (counter MSB)
//   pred_cnt       out  registered raw counter value
//   upd_valid      in   resolved branch outcome this cycle
//   upd_pc         in   PC of the resolved branch
//   upd_taken      in   actual outcome, 1 = taken
//   upd_count      out  number of applied updates, saturating
//   mispred_count  out  number of mispredicted updates, saturating
// ---------------------------------------------------------------------------
module bp_sat_table #(
  parameter int CNT_W  = 2,
  parameter int IDX_W  = 6,
  parameter int PC_W   = 32,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_out_valid,
  output logic              pred_taken,
  output logic [CNT_W-1:0]  pred_cnt,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  output logic [STAT_W-1:0] upd_count,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Saturating one-step walk of a counter toward taken or not-taken.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic taken);
    if (taken) return (c == CNT_MAX) ? c : c + 1'b1;
    else       return (c == '0)      ? c : c - 1'b1;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] table_q [DEPTH];

  logic [IDX_W-1:0] pred_idx_p0;
  logic [IDX_W-1:0] upd_idx_p0;
  logic [CNT_W-1:0] upd_old_p0;
  logic [CNT_W-1:0] upd_new_p0;
  logic             mispred_p0;
  logic [CNT_W-1:0] pred_cnt_p0;

  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [STAT_W-1:0] upd_count_p1;
  logic [STAT_W-1:0] mispred_count_p1;

  // Only pc[IDX_W+1:2] feed the index; the remaining PC bits are don't-care.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  logic [IDX_W:0]   ghr_shift;

  assign pred_idx_p0 = pred_pc[IDX_W+1:2] ^ ghr;
  assign upd_idx_p0  = upd_pc[IDX_W+1:2] ^ ghr;
  // Shift the resolved outcome in at the LSB; the old MSB falls off.
  assign ghr_shift   = {ghr, upd_taken};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= ghr_shift[IDX_W-1:0];
    end
  end
`else
  assign pred_idx_p0 = pred_pc[IDX_W+1:2];
  assign upd_idx_p0  = upd_pc[IDX_W+1:2];
`endif

  // ---- stage p0: table read, update compute, same-index forwarding ----
  assign upd_old_p0  = table_q[upd_idx_p0];
  assign upd_new_p0  = cnt_step(upd_old_p0, upd_taken);
  assign mispred_p0  = upd_old_p0[CNT_W-1] != upd_taken;
  // A lookup colliding with this edge's update sees the post-update value.
  assign pred_cnt_p0 = (upd_valid && (upd_idx_p0 == pred_idx_p0)) ?
                       upd_new_p0 : table_q[pred_idx_p0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= CNT_WNT;
      end
    end else if (upd_valid) begin
      table_q[upd_idx_p0] <= upd_new_p0;
    end
  end

  // ---- stage p1: registered prediction and statistics ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      vld_p1 <= pred_valid;
      if (pred_valid) begin
        cnt_p1 <= pred_cnt_p0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_count_p1     <= '0;
      mispred_count_p1 <= '0;
    end else if (upd_valid) begin
      upd_count_p1 <= stat_inc(upd_count_p1);
      if (mispred_p0) begin
        mispred_count_p1 <= stat_inc(mispred_count_p1);
      end
    end
  end

  assign pred_out_valid = vld_p1;
  assign pred_cnt       = cnt_p1;
  assign pred_taken     = cnt_p1[CNT_W-1];
  assign upd_count      = upd_count_p1;
  assign mispred_count  = mispred_count_p1;

endmodule

// File: tb/tb_bp_sat_table.sv
// ---------------------------------------------------------------------------
// tb_bp_sat_table
//
// Self-checking bench for bp_sat_table. A behavioural model (integer array
// of counters, clamped arithmetic) tracks the table; directed sequences
// cover the documented scenarios and a randomized phase with occasional
// asynchronous resets covers the rest. STAT_W is reduced so statistics
// saturation is reachable.
// ---------------------------------------------------------------------------
module tb_bp_sat_table;

  localparam int CNT_W  = 2;
  localparam int IDX_W  = 6;
  localparam int PC_W   = 32;
  localparam int STAT_W = 5;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int SMAX   = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pred_valid = 1'b0;
  logic [PC_W-1:0]   pred_pc = '0;
  logic              pred_out_valid;
  logic              pred_taken;
  logic [CNT_W-1:0]  pred_cnt;
  logic              upd_valid = 1'b0;
  logic [PC_W-1:0]   upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic [STAT_W-1:0] upd_count;
  logic [STAT_W-1:0] mispred_count;

  bp_sat_table #(
    .CNT_W (CNT_W),
    .IDX_W (IDX_W),
    .PC_W  (PC_W),
    .STAT_W(STAT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_out_valid(pred_out_valid),
    .pred_taken    (pred_taken),
    .pred_cnt      (pred_cnt),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_count     (upd_count),
    .mispred_count (mispred_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---- behavioural reference model ----
  int m_tab [DEPTH];
  int m_ghr;
  int m_upd;
  int m_mis;
  int m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_tab[i] = (1 << (CNT_W - 1)) - 1;
    m_ghr = 0;
    m_upd = 0;
    m_mis = 0;
    m_cnt = 0;
  endfunction

  function automatic int model_idx(input int pc);
    int idx;
    idx = (pc >> 2) % DEPTH;
`ifdef BP_GSHARE_EN
    idx = idx ^ m_ghr;
`endif
    return idx;
  endfunction

  // One clock: drive at negedge, advance model at the edge, check #1 later.
  task automatic step(input bit pv, input int ppc, input bit uv,
                      input int upc, input bit ut);
    int pi, ui, old;
    @(negedge clk);
    pred_valid = pv;
    pred_pc    = ppc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    @(posedge clk);
    pi = model_idx(ppc);
    ui = model_idx(upc);
    if (uv) begin
      old = m_tab[ui];
      if ((old >> (CNT_W - 1)) != int'(ut) && m_mis < SMAX) m_mis++;
      if (m_upd < SMAX) m_upd++;
      m_tab[ui] = ut ? ((old + 1 > CMAX) ? CMAX : old + 1)
                     : ((old - 1 < 0) ? 0 : old - 1);
      m_ghr = ((m_ghr << 1) | int'(ut)) % DEPTH;
    end
    if (pv) m_cnt = m_tab[pi];
    #1;
    check_val("pred_out_valid", pred_out_valid, pv);
    check_val("pred_cnt", pred_cnt, m_cnt);
    check_val("pred_taken", pred_taken, m_cnt >> (CNT_W - 1));
    check_val("upd_count", upd_count, m_upd);
    check_val("mispred_count", mispred_count, m_mis);
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_val("rst_pred_out_valid", pred_out_valid, 0);
    check_val("rst_pred_taken", pred_taken, 0);
    check_val("rst_pred_cnt", pred_cnt, 0);
    check_val("rst_upd_count", upd_count, 0);
    check_val("rst_mispred_count", mispred_count, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_seq [4] = '{2, 1, 0, 0};

  initial begin
    model_reset();
    #2;
    check_val("init_pred_out_valid", pred_out_valid, 0);
    check_val("init_pred_cnt", pred_cnt, 0);
    check_val("init_upd_count", upd_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // First lookup after reset reads weak not-taken.
    step(1, 'h40, 0, 0, 0);
    check_val("first_lookup_cnt", pred_cnt, 1);
    check_val("first_lookup_taken", pred_taken, 0);

    // Walk up to strong taken, saturate at the top.
    repeat (3) step(0, 0, 1, 'h40, 1);
    step(1, 'h40, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check_val("sat_up_cnt", pred_cnt, 3);
    check_val("sat_up_taken", pred_taken, 1);
`endif
    step(0, 0, 1, 'h40, 1);
    step(1, 'h40, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check_val("sat_top_cnt", pred_cnt, 3);
    check_val("sat_top_mispred", mispred_count, 1);
`endif

    // Walk down with hysteresis, saturate at zero.
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 'h40, 0);
      step(1, 'h40, 0, 0, 0);
`ifndef BP_GSHARE_EN
      check_val("walk_down_cnt", pred_cnt, exp_seq[k]);
`endif
    end

    // Same-edge lookup and update: forwarding, then independent index.
    async_reset();
    step(1, 'h80, 1, 'h80, 1);
    check_val("fwd_cnt", pred_cnt, 2);
    check_val("fwd_taken", pred_taken, 1);
    step(1, 'h84, 1, 'h80, 1);
`ifndef BP_GSHARE_EN
    check_val("nofwd_cnt", pred_cnt, 1);
`endif

    // Aliasing, then reset mid-stream.
    async_reset();
    step(0, 0, 1, 'h100, 1);
    step(1, 'h0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check_val("alias_cnt", pred_cnt, 2);
`endif
    step(1, 'h40, 0, 0, 0);
    async_reset();
    step(1, 'h40, 0, 0, 0);
    check_val("post_reset_cnt", pred_cnt, 1);

    // History-dependent indexing versus pure PC indexing.
    async_reset();
    step(0, 0, 1, 'h0, 1);
    step(0, 0, 1, 'h0, 1);
`ifdef BP_GSHARE_EN
    step(1, 'hC, 0, 0, 0);
    check_val("gshare_cnt", pred_cnt, 2);
`else
    step(1, 'h0, 0, 0, 0);
    check_val("pc_idx_cnt", pred_cnt, 3);
`endif

    // Randomized phase on a small PC window to force collisions.
    async_reset();
    for (int n = 0; n < 3000; n++) begin
      int ppc, upc;
      ppc = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 15) << 2);
      upc = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 15) << 2);
      step(bit'($urandom_range(0, 1)), ppc, bit'($urandom_range(0, 1)), upc,
           bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_sat_table.md
# bp_sat_table

Parametrised branch predictor table: a direct-mapped array of 2^IDX_W saturating counters, each CNT_W bits wide, indexed by branch PC. It sits in the fetch/decode front end. It provides a registered taken/not-taken prediction for a lookup PC and applies resolved branch outcomes through a separate update port. It also keeps running counts of updates and mispredictions for performance analysis.

## Interface
- CNT_W, 2, counter width in bits (legal 1..4)
- IDX_W, 6, index width; table depth = 2^IDX_W entries
- PC_W, 32, PC width; requires PC_W >= IDX_W+2
- STAT_W, 16, width of the statistics counters
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- pred_valid  in  1  lookup request this cycle
- pred_pc  in  PC_W  PC of the branch being looked up
- pred_out_valid  out  1  registered; high one cycle after accepted lookup
- pred_taken  out  1  registered prediction (counter MSB)
- pred_cnt  out  CNT_W  registered raw counter value used for the prediction
- upd_valid  in  1  resolved branch outcome this cycle
- upd_pc  in  PC_W  PC of resolved branch
- upd_taken  in  1  actual outcome: 1 = taken, 0 = not taken
- upd_count  out  STAT_W  number of updates applied, saturating
- mispred_count  out  STAT_W  number of updates whose pre-update counter MSB != upd_taken, saturating

## Operation
- Index: idx = pc[IDX_W+1:2] (word-aligned PCs); see Configuration for gshare variant.
- Counter encoding: 0 = strongest not-taken, 2^CNT_W-1 = strongest taken; prediction = counter[CNT_W-1].
- Reset value of every entry: WNT = 2^(CNT_W-1)-1 (CNT_W=2 -> 1 = weak not-taken; CNT_W=1 -> 0).
- Update with upd_taken=1: cnt = min(cnt+1, 2^CNT_W-1). Update with upd_taken=0: cnt = max(cnt-1, 0). No wrap-around at either end.
- Hysteresis follows from the saturating walk; no jumps between strong states.
- Misprediction for statistics = MSB of the entry before the update != upd_taken.
- upd_count / mispred_count increment by 1 per applied update. They hold at 2^STAT_W-1.
- Outputs on reset: pred_out_valid=0, pred_taken=0, pred_cnt=0, upd_count=0, mispred_count=0.
- Reset asserted mid-operation clears table, outputs and statistics immediately, without waiting for a clock edge. A lookup in flight is dropped (pred_out_valid=0).

## Timing
- Lookup latency: 1 cycle. pred_valid sampled at edge N; pred_out_valid/pred_taken/pred_cnt are valid after edge N and held until the next accepted lookup.
- pred_out_valid is a 1-cycle pulse per lookup. Back-to-back lookups every cycle are supported.
- Update: the read-modify-write is committed at the edge where upd_valid=1. It is visible to lookups sampled at later edges.
- Simultaneous lookup and update, same index, same edge: the lookup returns the post-update counter (write forwarding).
- Simultaneous lookup and update, different index: both proceed independently, no stall.
- No backpressure; the block always accepts both ports.

## Configuration
- BP_GSHARE_EN defined: the block holds an IDX_W-bit global history register ghr, reset 0.
  - Lookup index = pc[IDX_W+1:2] ^ ghr.
  - Update index = upd_pc[IDX_W+1:2] ^ ghr, using ghr before this cycle's shift.
  - On each update: ghr = {ghr[IDX_W-2:0], upd_taken}.
  - Forwarding compares the XORed indices.
  - Correct operation assumes at most one unresolved branch between lookup and update.
- BP_GSHARE_EN undefined: no history register; pure PC indexing as above.

## Test plan
- Reset, then lookup pc=0x40 -> pred_taken=0, pred_cnt=1 one cycle later; upd_count=0, mispred_count=0.
- Three updates taken at pc=0x40, then lookup -> pred_cnt=3, pred_taken=1. Fourth taken update -> pred_cnt stays 3. mispred_count=1 (first update only).
- From cnt=3, four not-taken updates at pc=0x40 -> lookups read 2,1,0,0; pred_taken flips to 0 after the second update.
- Same edge: lookup and taken update both at pc=0x80 (cnt 1) -> pred_cnt=2, pred_taken=1. Lookup pc=0x84 on the same edge -> unaffected, cnt=1.
- Aliasing: with IDX_W=6, update taken at pc=0x100 -> lookup pc=0x0 reads cnt=2. Assert reset mid-stream -> all outputs 0 immediately; next lookup reads cnt=1.
- With BP_GSHARE_EN: updates taken,taken at pc=0x0 write idx 0 then idx 1. ghr=3, so lookup pc=0xC reads idx 0 (cnt=2). Without the macro, the same sequence leaves idx 0 cnt=3.
